mem_port_arbiter: RTL

- Shares one memory instance (one write port, one combinational read port) between two requesters, A and B.
- Each cycle it grants at most one write and at most one read, independently, with round-robin priority per port.
- Read data is registered and returned to the winning requester one cycle after its grant.
- Sits between client logic and the memory array module.

---
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory (one write port, one combinational
// read port) between requesters A and B. Writes and reads are arbitrated
// independently, each with its own round-robin pointer. Read data is
// registered and returned to the read winner one cycle after its grant.
//
// Optional feature macro: MEM_ARB_FWD_EN
//   defined   -> a same-cycle write and read to the same address return the
//                new (write) data
//   undefined -> the read returns the pre-write memory contents
module mem_port_arbiter #(
  parameter int ADDR_SIZE = 4,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [BYTE_SIZE-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [BYTE_SIZE-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [BYTE_SIZE-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [BYTE_SIZE-1:0] b_rdata,
  output logic                 mem_wen,
  output logic [ADDR_SIZE-1:0] mem_waddr,
  output logic [BYTE_SIZE-1:0] mem_wdata,
  output logic [ADDR_SIZE-1:0] mem_raddr,
  input  logic [BYTE_SIZE-1:0] mem_rdata
);

  typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_e;

  sel_e wr_ptr, rd_ptr;

  logic a_wc, b_wc, a_rc, b_rc;
  logic a_wwin, b_wwin, a_rwin, b_rwin;
  logic rd_any;
  logic [BYTE_SIZE-1:0] rd_result;

  // Candidates; reset masks every request so nothing is granted while it is high.
  assign a_wc = !reset && a_req &&  a_we;
  assign b_wc = !reset && b_req &&  b_we;
  assign a_rc = !reset && a_req && !a_we;
  assign b_rc = !reset && b_req && !b_we;

  // A lone candidate always wins; on contention the pointer decides.
  assign a_wwin = a_wc && (!b_wc || (wr_ptr == SEL_A));
  assign b_wwin = b_wc && (!a_wc || (wr_ptr == SEL_B));
  assign a_rwin = a_rc && (!b_rc || (rd_ptr == SEL_A));
  assign b_rwin = b_rc && (!a_rc || (rd_ptr == SEL_B));
  assign rd_any = a_rwin | b_rwin;

  assign a_gnt = a_wwin | a_rwin;
  assign b_gnt = b_wwin | b_rwin;

  // Memory-side muxes; idle ports drive zero.
  assign mem_wen   = a_wwin | b_wwin;
  assign mem_waddr = a_wwin ? a_addr  : (b_wwin ? b_addr  : '0);
  assign mem_wdata = a_wwin ? a_wdata : (b_wwin ? b_wdata : '0);
  assign mem_raddr = a_rwin ? a_addr  : (b_rwin ? b_addr  : '0);

`ifdef MEM_ARB_FWD_EN
  // Same-cycle write to the read address: return the data being written.
  assign rd_result = (mem_wen && rd_any && (mem_waddr == mem_raddr)) ? mem_wdata : mem_rdata;
`else
  // Memory commits the write at the edge, so the read sees old contents.
  assign rd_result = mem_rdata;
`endif

  // Round-robin pointers: after any grant point at the requester that did not win.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= SEL_A;
      rd_ptr <= SEL_A;
    end else begin
      if (mem_wen) wr_ptr <= a_wwin ? SEL_B : SEL_A;
      if (rd_any)  rd_ptr <= a_rwin ? SEL_B : SEL_A;
    end
  end

  // Read return: one-cycle rvalid pulse to the winner; loser keeps its data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_rwin;
      b_rvalid <= b_rwin;
      if (a_rwin) a_rdata <= rd_result;
      if (b_rwin) b_rdata <= rd_result;
    end
  end

endmodule
